// File: rtl/cpu_pkg.sv
// Shared front-end types: PC width, reset vector and the IF/ID and ID/EX
// pipeline register layouts reused by the decode/execute stages.
`default_nettype none

package cpu_pkg;

   localparam int PC_W = 32;
   localparam logic [PC_W-1:0] RESET_PC_DFLT = 32'h0000_0000;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            ptaken;
      logic            valid;
   } if_id_t;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic            ptaken;
      logic            is_branch;
      logic            valid;
   } id_ex_t;

   // Instructions are word aligned; the BTB may hand back junk in bits [1:0].
   function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] a);
      return {a[PC_W-1:2], 2'b00};
   endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// Saturating up-counter with a freeze input; sticks at all-ones instead of wrapping.
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             hold,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] MAX_CNT = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (!hold && inc && (count != MAX_CNT)) begin
         count <= count + ONE;
      end
   end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_pipe.sv
// Fetch PC generator plus the IF/ID -> ID/EX prediction-tracking pipe that
// feeds the BTB lookup (stage 1) and update (stage 3) ports.
`default_nettype none

module fetch_pc_pipe
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             memory_stall,
   input  logic             hazard_stall,
   input  logic [31:0]      pred_pc,
   input  logic             pred_taken,
   input  logic             flush,
   input  logic             is_branch_id,
   output logic [31:0]      pc_if,
   output logic [31:0]      pc_ex,
   output logic             prev_taken_ex,
   output logic             is_branch_ex,
   output logic             valid_ex,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   logic [PC_W-1:0] pc_r;
   if_id_t          if_id;
   id_ex_t          id_ex;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_r  <= align_pc(RESET_PC);
         if_id <= '0;
         id_ex <= '0;
      end else if (memory_stall) begin
         // Full freeze; a pending flush stays asserted and is taken later.
         pc_r  <= pc_r;
         if_id <= if_id;
         id_ex <= id_ex;
      end else if (flush) begin
         pc_r        <= align_pc(pred_pc);
         if_id.valid <= 1'b0;
         id_ex.valid <= 1'b0;
      end else if (hazard_stall) begin
         id_ex.valid <= 1'b0;
      end else begin
         pc_r            <= align_pc(pred_pc);
         if_id.pc        <= pc_r;
         if_id.ptaken    <= pred_taken;
         if_id.valid     <= 1'b1;
         id_ex.pc        <= if_id.pc;
         id_ex.ptaken    <= if_id.ptaken;
         id_ex.is_branch <= is_branch_id;
         id_ex.valid     <= if_id.valid;
      end
   end

   assign pc_if         = pc_r;
   assign pc_ex         = id_ex.pc;
   assign prev_taken_ex = id_ex.ptaken & id_ex.valid;
   assign is_branch_ex  = id_ex.is_branch & id_ex.valid;
   assign valid_ex      = id_ex.valid;

   logic mispredict_inc;
   assign mispredict_inc = is_branch_ex & flush;

   sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (is_branch_ex),
      .hold  (memory_stall),
      .count (branch_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (mispredict_inc),
      .hold  (memory_stall),
      .count (mispredict_cnt)
   );

endmodule

`default_nettype wire
